// File: rtl/issue_scoreboard_pkg.sv
// Shared scoreboard constants and the drain FSM state type.
// Every scoreboard file imports this package.
package Scoreboard;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;
    localparam int unsigned TOTAL_W    = 6;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/issue_scoreboard_counter.sv
// In-flight write counter for a single architectural register.
// Clear has priority. An increment and a decrement in the same cycle cancel out.
module reg_pending_counter
    import Scoreboard::*;
#(
    parameter int unsigned CNT_W = Scoreboard::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_max
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_max;
    logic             w_nz;

    assign w_max = (r_cnt == '1);
    assign w_nz  = (r_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !w_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && w_nz) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_max = w_max;

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard. It tracks pending writes for each register,
// stalls decode on RAW or counter-saturation hazards, and provides flush and drain control.
module issue_scoreboard
    import Scoreboard::*;
#(
    parameter int unsigned NUM_REGS = Scoreboard::NUM_REGS,
    parameter int unsigned CNT_W    = Scoreboard::CNT_W,
    parameter int unsigned TOTAL_W  = Scoreboard::TOTAL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  issue_rs1_used,
    input  logic                  issue_rs2_used,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_rd_write,
    input  logic                  ds_stall,
    output logic                  issue_stall,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic [NUM_REGS-1:0]   busy,
    output logic [TOTAL_W-1:0]    inflight,
    output logic                  err_underflow
);

    localparam int unsigned ADDR_SPACE = 1 << REG_ADDR_W;

    logic [CNT_W-1:0]   w_cnt [ADDR_SPACE];
    logic               w_max [ADDR_SPACE];
    logic [TOTAL_W-1:0] r_inflight;
    sb_state_t          r_state;
    logic               r_drain_done;
    logic               r_err;

    logic w_hazard;
    logic w_fire;
    logic w_inc_any;
    logic w_wb_hit;
    logic w_wb_miss;

    // Unused addresses (x0 and any address at or above NUM_REGS) read as an idle counter.
    for (genvar r = 0; r < ADDR_SPACE; r++) begin : g_reg
        if (r == 0 || r >= NUM_REGS) begin : g_none
            assign w_cnt[r] = '0;
            assign w_max[r] = 1'b0;
        end else begin : g_ctr
            reg_pending_counter #(.CNT_W(CNT_W)) u_ctr (
                .clk   (clk),
                .rst   (rst),
                .i_inc (w_inc_any && (issue_rd == REG_ADDR_W'(r))),
                .i_dec (w_wb_hit && (wb_rd == REG_ADDR_W'(r))),
                .i_clr (flush),
                .o_cnt (w_cnt[r]),
                .o_max (w_max[r])
            );
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
        assign busy[r] = (w_cnt[r] != '0);
    end

    assign w_hazard = (issue_rs1_used && (issue_rs1 != '0) && (w_cnt[issue_rs1] != '0))
                    | (issue_rs2_used && (issue_rs2 != '0) && (w_cnt[issue_rs2] != '0))
                    | (issue_rd_write && (issue_rd != '0) && w_max[issue_rd]);

    assign issue_stall = issue_valid && (w_hazard || ds_stall || (r_state != RUN)
                                         || (r_inflight == '1));
    assign w_fire      = issue_valid && !issue_stall;
    assign w_inc_any   = w_fire && issue_rd_write && (issue_rd != '0) && !flush;
    assign w_wb_hit    = wb_valid && (wb_rd != '0) && (w_cnt[wb_rd] != '0) && !flush;
    assign w_wb_miss   = wb_valid && (wb_rd != '0) && (w_cnt[wb_rd] == '0) && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
        end else if (flush) begin
            r_inflight <= '0;
        end else if (w_inc_any && !w_wb_hit) begin
            r_inflight <= r_inflight + TOTAL_W'(1);
        end else if (w_wb_hit && !w_inc_any) begin
            r_inflight <= r_inflight - TOTAL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_wb_miss) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_drain_done <= 1'b0;
        end else if (flush) begin
            r_state      <= RUN;
            r_drain_done <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (drain_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_req) begin
                        r_state <= RUN;
                    end else if (r_inflight == '0) begin
                        r_state      <= DONE;
                        r_drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!drain_req) begin
                        r_state      <= RUN;
                        r_drain_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= RUN;
                    r_drain_done <= 1'b0;
                end
            endcase
        end
    end

    assign inflight      = r_inflight;
    assign drain_done    = r_drain_done;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard.
// Covers RAW, saturation, simultaneous inc/dec, x0, drain, flush, reset and the total limit.
module tb_issue_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_rs1_used;
    logic        issue_rs2_used;
    logic [4:0]  issue_rd;
    logic        issue_rd_write;
    logic        ds_stall;
    logic        issue_stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        drain_req;
    logic        drain_done;
    logic [31:0] busy;
    logic [5:0]  inflight;
    logic        err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    issue_scoreboard #(.NUM_REGS(32), .CNT_W(2), .TOTAL_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_write (issue_rd_write),
        .ds_stall       (ds_stall),
        .issue_stall    (issue_stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .busy           (busy),
        .inflight       (inflight),
        .err_underflow  (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_rs1      = '0;
        issue_rs2      = '0;
        issue_rs1_used = 1'b0;
        issue_rs2_used = 1'b0;
        issue_rd       = '0;
        issue_rd_write = 1'b0;
        ds_stall       = 1'b0;
        wb_valid       = 1'b0;
        wb_rd          = '0;
        flush          = 1'b0;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        issue_valid    = 1'b1;
        issue_rd       = rd;
        issue_rd_write = 1'b1;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    initial begin
        rst       = 1'b0;
        drain_req = 1'b0;
        idle();
        #1;
        check("rst_busy", busy, 32'h0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        check("rst_stall_idle", 32'(issue_stall), 32'd0);
        issue_valid = 1'b1;
        ds_stall    = 1'b1;
        #1;
        check("rst_stall_ds", 32'(issue_stall), 32'd1);
        idle();
        tick();
        tick();
        rst = 1'b1;
        tick();

        // RAW hazard on x5
        issue_wr(5'd5);
        #1 check("raw_fire_nostall", 32'(issue_stall), 32'd0);
        tick();
        idle();
        check("raw_busy_set", busy, 32'h20);
        check("raw_inflight1", 32'(inflight), 32'd1);
        issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs1_used = 1'b1;
        #1 check("raw_stall", 32'(issue_stall), 32'd1);
        tick();
        check("raw_stall_hold", 32'(issue_stall), 32'd1);
        wb(5'd5);
        #1 check("raw_stall_same_wb", 32'(issue_stall), 32'd1);
        tick();
        wb_valid = 1'b0;
        check("raw_busy_clear", busy, 32'h0);
        check("raw_inflight0", 32'(inflight), 32'd0);
        #1 check("raw_release", 32'(issue_stall), 32'd0);
        tick();
        idle();

        // Saturation on x7
        issue_wr(5'd7);
        tick(); tick(); tick();
        check("sat_inflight3", 32'(inflight), 32'd3);
        check("sat_busy", busy, 32'h80);
        check("sat_stall", 32'(issue_stall), 32'd1);
        wb(5'd7);
        #1 check("sat_stall_same_wb", 32'(issue_stall), 32'd1);
        tick();
        wb_valid = 1'b0;
        check("sat_inflight2", 32'(inflight), 32'd2);
        #1 check("sat_release", 32'(issue_stall), 32'd0);
        tick();
        idle();
        check("sat_refill", 32'(inflight), 32'd3);
        wb(5'd7);
        tick(); tick(); tick();
        idle();
        check("sat_drained", 32'(inflight), 32'd0);

        // Simultaneous fire and writeback on x9
        issue_wr(5'd9);
        tick();
        check("sim_inflight1", 32'(inflight), 32'd1);
        wb(5'd9);
        #1 check("sim_nostall", 32'(issue_stall), 32'd0);
        tick();
        idle();
        check("sim_inflight_same", 32'(inflight), 32'd1);
        check("sim_busy", busy, 32'h200);
        wb(5'd9);
        tick();
        idle();
        check("sim_inflight0", 32'(inflight), 32'd0);

        // x0 is never tracked
        issue_valid = 1'b1; issue_rs1_used = 1'b1; issue_rs2_used = 1'b1; issue_rd_write = 1'b1;
        #1 check("x0_nostall", 32'(issue_stall), 32'd0);
        tick();
        idle();
        check("x0_inflight", 32'(inflight), 32'd0);
        wb(5'd0);
        tick();
        idle();
        check("x0_err", 32'(err_underflow), 32'd0);
        check("x0_busy", busy, 32'h0);

        // Drain with two pending writes
        issue_wr(5'd1); tick();
        issue_wr(5'd2); tick();
        idle();
        check("drn_inflight2", 32'(inflight), 32'd2);
        drain_req = 1'b1;
        tick();
        issue_valid = 1'b1;
        #1 check("drn_stall", 32'(issue_stall), 32'd1);
        issue_valid = 1'b0;
        wb(5'd1); tick();
        check("drn_inflight1", 32'(inflight), 32'd1);
        wb(5'd2); tick();
        idle();
        check("drn_inflight0", 32'(inflight), 32'd0);
        check("drn_not_yet", 32'(drain_done), 32'd0);
        tick();
        check("drn_done", 32'(drain_done), 32'd1);
        issue_valid = 1'b1;
        #1 check("drn_done_stall", 32'(issue_stall), 32'd1);
        issue_valid = 1'b0;
        drain_req = 1'b0;
        tick();
        check("drn_back_run", 32'(drain_done), 32'd0);
        issue_valid = 1'b1;
        #1 check("drn_run_nostall", 32'(issue_stall), 32'd0);
        idle();

        // Flush with four pending writes, and flush forcing RUN
        for (int r = 1; r <= 4; r++) begin
            issue_wr(5'(r));
            tick();
        end
        idle();
        check("fl_inflight4", 32'(inflight), 32'd4);
        check("fl_busy", busy, 32'h1E);
        drain_req = 1'b1;
        tick();
        flush = 1'b1;
        wb(5'd1);
        tick();
        idle();
        check("fl_inflight0", 32'(inflight), 32'd0);
        check("fl_busy0", busy, 32'h0);
        check("fl_err0", 32'(err_underflow), 32'd0);
        issue_valid = 1'b1;
        #1 check("fl_state_run", 32'(issue_stall), 32'd0);
        idle();
        drain_req = 1'b0;
        tick();
        wb(5'd3);
        tick();
        idle();
        check("fl_underflow", 32'(err_underflow), 32'd1);
        check("fl_underflow_cnt", 32'(inflight), 32'd0);
        tick(); tick();
        check("fl_err_sticky", 32'(err_underflow), 32'd1);
        #2 rst = 1'b0;
        #1 check("rst_async_err", 32'(err_underflow), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Total in-flight limit: 21 registers x 3 writes = 63
        for (int r = 1; r <= 21; r++) begin
            issue_wr(5'(r));
            tick(); tick(); tick();
        end
        idle();
        check("tot_inflight_max", 32'(inflight), 32'd63);
        issue_valid = 1'b1;
        #1 check("tot_stall", 32'(issue_stall), 32'd1);
        idle();
        flush = 1'b1;
        tick();
        idle();
        check("tot_flushed", 32'(inflight), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
